// File: rtl/mem_bridge_if.sv
// Core <-> external-memory bridge bundle.
// slave  : the bridge itself (takes core requests, drives memory strobes)
// master : the environment (core request side plus the memory data return)
interface mem_bridge_if;
    // Core-facing request / response
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_instr;
    logic        cpu_read_done;
    logic [15:0] cpu_rdata;
    logic [31:0] cpu_idata;
    logic        cpu_busy;
    logic        cpu_ready;
    // External 16-bit memory pins
    logic [16:0] mem_addr;
    logic        mem_half;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_we;
    logic        mem_oe;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_instr, cpu_read_done,
        input  mem_rdata,
        output cpu_rdata, cpu_idata, cpu_busy, cpu_ready,
        output mem_addr, mem_half, mem_wdata, mem_we, mem_oe
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_instr, cpu_read_done,
        output mem_rdata,
        input  cpu_rdata, cpu_idata, cpu_busy, cpu_ready,
        input  mem_addr, mem_half, mem_wdata, mem_we, mem_oe
    );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: turns level-held core requests into timed 16-bit memory cycles
// with WAIT_CYCLES extra wait states, and assembles 32-bit instruction words
// from two half reads.
// Optional build macro MEM_BRIDGE_IBUF_EN adds a one-entry instruction buffer
// that lets a repeated fetch of the same address skip the memory entirely.
module mem_bridge #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_bridge_if.slave  bus
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR,
        HOLD,
        WDONE
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last_cnt;

    assign last_cnt = (wait_cnt == WAIT_LAST);

`ifdef MEM_BRIDGE_IBUF_EN
    logic        ibuf_valid;
    logic [15:0] ibuf_addr;
    logic [31:0] ibuf_word;
    logic        ibuf_hit;

    // Buffer hit: instruction fetch to the address held in a valid entry.
    assign ibuf_hit = bus.cpu_instr && ibuf_valid && (ibuf_addr == bus.cpu_addr);
`endif

    // Access sequencer; every core and memory output is a flop set here.
    // NOTE: strobes sit in the async-reset branch so mem_we/mem_oe drop the
    // moment rst falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            bus.cpu_rdata <= '0;
            bus.cpu_idata <= '0;
            bus.cpu_busy  <= 1'b0;
            bus.cpu_ready <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_half  <= 1'b0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_oe    <= 1'b0;
`ifdef MEM_BRIDGE_IBUF_EN
            ibuf_valid    <= 1'b0;
            ibuf_addr     <= '0;
            ibuf_word     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; every branch reads
            // the pre-edge value of state and the other registers.
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (bus.cpu_write) begin
                        // Write wins over a simultaneous read; the read level
                        // is still held and gets taken after WDONE.
                        state         <= WR;
                        bus.mem_addr  <= {bus.cpu_instr, bus.cpu_addr};
                        bus.mem_half  <= 1'b0;
                        bus.mem_wdata <= bus.cpu_wdata;
                        bus.mem_we    <= 1'b1;
                        bus.cpu_busy  <= 1'b1;
`ifdef MEM_BRIDGE_IBUF_EN
                        ibuf_valid    <= 1'b0;
`endif
                    end else if (bus.cpu_read) begin
`ifdef MEM_BRIDGE_IBUF_EN
                        if (ibuf_hit) begin
                            state         <= HOLD;
                            bus.cpu_idata <= ibuf_word;
                            bus.cpu_rdata <= ibuf_word[15:0];
                            bus.cpu_ready <= 1'b1;
                        end else
`endif
                        begin
                            state        <= RD_LO;
                            bus.mem_addr <= {bus.cpu_instr, bus.cpu_addr};
                            bus.mem_half <= 1'b0;
                            bus.mem_oe   <= 1'b1;
                            bus.cpu_busy <= 1'b1;
                        end
                    end
                end

                WR: begin
                    if (last_cnt) begin
                        state         <= WDONE;
                        bus.mem_we    <= 1'b0;
                        bus.cpu_busy  <= 1'b0;
                        bus.cpu_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                WDONE: begin
                    state         <= IDLE;
                    bus.cpu_ready <= 1'b0;
                end

                RD_LO: begin
                    if (last_cnt) begin
                        bus.cpu_rdata       <= bus.mem_rdata;
                        bus.cpu_idata[15:0] <= bus.mem_rdata;
                        wait_cnt            <= '0;
                        // mem_addr[16] is the latched instruction-space flag.
                        if (bus.mem_addr[16]) begin
                            state        <= RD_HI;
                            bus.mem_half <= 1'b1;
                        end else begin
                            state         <= HOLD;
                            bus.mem_oe    <= 1'b0;
                            bus.cpu_busy  <= 1'b0;
                            bus.cpu_ready <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                RD_HI: begin
                    if (last_cnt) begin
                        state                <= HOLD;
                        bus.cpu_idata[31:16] <= bus.mem_rdata;
                        bus.mem_oe           <= 1'b0;
                        bus.cpu_busy         <= 1'b0;
                        bus.cpu_ready        <= 1'b1;
`ifdef MEM_BRIDGE_IBUF_EN
                        ibuf_valid           <= 1'b1;
                        ibuf_addr            <= bus.mem_addr[15:0];
                        ibuf_word            <= {bus.mem_rdata, bus.cpu_idata[15:0]};
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                HOLD: begin
                    // Data stays put until the core acknowledges; new
                    // request levels are ignored here.
                    if (bus.cpu_read_done) begin
                        state         <= IDLE;
                        bus.cpu_ready <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    wait_cnt      <= '0;
                    bus.mem_we    <= 1'b0;
                    bus.mem_oe    <= 1'b0;
                    bus.cpu_busy  <= 1'b0;
                    bus.cpu_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Testbench for mem_bridge: directed scenarios followed by random accesses,
// all checked against a transaction-level model (latency formulas, a sparse
// memory array and, when MEM_BRIDGE_IBUF_EN is defined, a last-fetch record).
module tb_mem_bridge;

    localparam int W      = 2;
    localparam int BUDGET = 64;

    logic clk = 1'b0;
    logic rst;

    mem_bridge_if bus();

    mem_bridge #(.WAIT_CYCLES(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory device contents, keyed by {mem_addr, mem_half}
    logic [15:0] mem [logic [17:0]];

    // Reference model state
    logic [31:0] exp_idata;
    bit          ib_valid;
    logic [15:0] ib_addr;
    logic [31:0] ib_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [16:0] a, input logic h);
        logic [17:0] k;
        logic [31:0] t;
        k = {a, h};
        if (mem.exists(k)) return mem[k];
        t = {14'd0, k} * 32'h9E3779B1;
        return t[31:16] ^ t[15:0];
    endfunction

    task automatic drive_req(input bit wr, input bit rd, input bit instr,
                             input logic [15:0] addr, input logic [15:0] wdata);
        bus.cpu_write = wr;
        bus.cpu_read  = rd;
        bus.cpu_instr = instr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    // Runs one access whose request levels are already on the pins; the next
    // rising edge is the sampling edge (edge 0). Returns at a falling edge
    // one cycle after the access has finished.
    task automatic run_access(input bit is_write, input bit instr, input logic [15:0] addr,
                              input logic [15:0] wdata, input int hold_extra);
        bit          hit;
        int          exp_ready, exp_strobes, ready_at, strobes, run;
        logic [16:0] exp_addr;
        logic [31:0] exp_word;
        logic [15:0] exp_rdata, d;
        logic        prev_oe, prev_half;

        hit = 1'b0;
`ifdef MEM_BRIDGE_IBUF_EN
        hit = !is_write && instr && ib_valid && (ib_addr == addr);
`endif
        exp_addr = {instr, addr};
        if (is_write) begin
            exp_ready   = W + 2;
            exp_strobes = W + 1;
        end else if (hit) begin
            exp_ready   = 1;
            exp_strobes = 0;
        end else if (instr) begin
            exp_ready   = 2 * W + 3;
            exp_strobes = 2 * (W + 1);
        end else begin
            exp_ready   = W + 2;
            exp_strobes = W + 1;
        end

        if (hit)        exp_word = ib_word;
        else if (instr) exp_word = {mem_rd(exp_addr, 1'b1), mem_rd(exp_addr, 1'b0)};
        else            exp_word = {exp_idata[31:16], mem_rd(exp_addr, 1'b0)};
        exp_rdata = exp_word[15:0];

        ready_at  = 0;
        strobes   = 0;
        run       = 0;
        prev_oe   = 1'b0;
        prev_half = 1'b0;

        @(posedge clk);
        for (int c = 1; c <= BUDGET && ready_at == 0; c++) begin
            @(negedge clk);
            if (bus.cpu_ready) ready_at = c;
            check("busy", 32'(bus.cpu_busy), 32'(c < exp_ready));
            if (bus.mem_we || bus.mem_oe) begin
                strobes++;
                check("strobe_addr", 32'(bus.mem_addr), 32'(exp_addr));
                check("strobe_kind", 32'(bus.mem_we), 32'(is_write));
                check("strobe_half", 32'(bus.mem_half), 32'(strobes > W + 1));
                if (bus.mem_we) begin
                    check("wdata", 32'(bus.mem_wdata), 32'(wdata));
                    mem[{bus.mem_addr, bus.mem_half}] = bus.mem_wdata;
                end
            end
            // Memory returns valid data only on the last cycle of each strobe run.
            if (bus.mem_oe) begin
                run = (prev_oe && prev_half == bus.mem_half) ? run + 1 : 1;
                d = mem_rd(bus.mem_addr, bus.mem_half);
                bus.mem_rdata = (run == W + 1) ? d : ~d;
            end else begin
                run = 0;
                bus.mem_rdata = 16'($urandom);
            end
            prev_oe   = bus.mem_oe;
            prev_half = bus.mem_half;
        end

        check("ready_cycle", 32'(ready_at), 32'(exp_ready));
        check("strobe_count", 32'(strobes), 32'(exp_strobes));

        if (is_write) begin
            bus.cpu_write = 1'b0;
            @(negedge clk);
            check("wr_ready_pulse", 32'(bus.cpu_ready), 32'h0);
            check("wr_idle_we", 32'(bus.mem_we), 32'h0);
            ib_valid = 1'b0;
        end else begin
            check("rdata", 32'(bus.cpu_rdata), 32'(exp_rdata));
            check("idata", bus.cpu_idata, exp_word);
            bus.cpu_read = 1'b0;
            for (int h = 0; h < hold_extra; h++) begin
                bus.cpu_write = 1'($urandom);
                @(negedge clk);
                check("hold_ready", 32'(bus.cpu_ready), 32'h1);
                check("hold_idata", bus.cpu_idata, exp_word);
                check("hold_strobes", 32'({bus.mem_we, bus.mem_oe}), 32'h0);
            end
            bus.cpu_write     = 1'b0;
            bus.cpu_read_done = 1'b1;
            @(negedge clk);
            check("done_ready", 32'(bus.cpu_ready), 32'h0);
            bus.cpu_read_done = 1'b0;
            exp_idata = exp_word;
            if (instr && !hit) begin
                ib_valid = 1'b1;
                ib_addr  = addr;
                ib_word  = exp_word;
            end
        end
    endtask

    initial begin
        bit          wr, rd, instr;
        int          k, spurious;
        logic [15:0] a, wd;

        rst = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.cpu_read_done = 1'b0;
        bus.mem_rdata     = 16'h0;
        exp_idata = 32'h0;
        ib_valid  = 1'b0;
        ib_addr   = 16'h0;
        ib_word   = 32'h0;
        mem[{17'h01234, 1'b0}] = 16'hBEEF;
        mem[{17'h10010, 1'b0}] = 16'h1111;
        mem[{17'h10010, 1'b1}] = 16'h2222;

        #1;
        check("rst_ready", 32'(bus.cpu_ready), 32'h0);
        check("rst_busy", 32'(bus.cpu_busy), 32'h0);
        check("rst_strobes", 32'({bus.mem_we, bus.mem_oe}), 32'h0);
        check("rst_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_idata", bus.cpu_idata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Data read, write, instruction fetches around a write
        drive_req(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0);
        run_access(1'b0, 1'b0, 16'h1234, 16'h0, 2);
        check("plan_rdata", 32'(mem_rd(17'h01234, 1'b0)), 32'h0000BEEF);
        drive_req(1'b1, 1'b0, 1'b0, 16'h0042, 16'hA5A5);
        run_access(1'b1, 1'b0, 16'h0042, 16'hA5A5, 0);
        drive_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
        run_access(1'b0, 1'b1, 16'h0010, 16'h0, 0);
        check("plan_idata", bus.cpu_idata, 32'h22221111);
        drive_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
        run_access(1'b0, 1'b1, 16'h0010, 16'h0, 1);
        drive_req(1'b1, 1'b0, 1'b0, 16'h0099, 16'h5555);
        run_access(1'b1, 1'b0, 16'h0099, 16'h5555, 0);
        drive_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
        run_access(1'b0, 1'b1, 16'h0010, 16'h0, 0);

        // Read and write together: write first, then the held read
        drive_req(1'b1, 1'b1, 1'b0, 16'h0300, 16'h7E57);
        run_access(1'b1, 1'b0, 16'h0300, 16'h7E57, 0);
        check("both_read_idle", 32'(bus.mem_oe), 32'h0);
        run_access(1'b0, 1'b0, 16'h0300, 16'h0, 0);

        // Asynchronous reset in the middle of a read
        drive_req(1'b0, 1'b1, 1'b0, 16'h0777, 16'h0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_oe", 32'(bus.mem_oe), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async_oe", 32'(bus.mem_oe), 32'h0);
        check("async_busy", 32'(bus.cpu_busy), 32'h0);
        check("async_ready", 32'(bus.cpu_ready), 32'h0);
        bus.cpu_read = 1'b0;
        exp_idata = 32'h0;
        ib_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.cpu_ready || bus.mem_oe || bus.mem_we) spurious++;
        end
        check("post_rst_quiet", 32'(spurious), 32'h0);
        check("post_rst_idata", bus.cpu_idata, 32'h0);

        // Random traffic over a small address pool so buffer hits occur
        for (int n = 0; n < 60; n++) begin
            k     = int'($urandom_range(0, 7));
            a     = (k == 7) ? 16'($urandom) : 16'h0010 + 16'($urandom_range(0, 2));
            wd    = 16'($urandom);
            instr = ($urandom_range(0, 2) != 0);
            wr    = (k < 2);
            rd    = !wr || (k == 0);
            drive_req(wr, rd, instr, a, wd);
            if (wr) begin
                run_access(1'b1, instr, a, wd, 0);
                if (rd) run_access(1'b0, instr, a, 16'h0, 0);
            end else begin
                run_access(1'b0, instr, a, 16'h0, int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Downstream of the CPU core's memory port: converts its level requests (read, write, instruction access, read-done) into timed cycles on a 16-bit external memory with a fixed wait-state count.
- Returns busy/ready status and read data to the core.
- Assembles 32-bit instruction words from two consecutive 16-bit half reads.
- Sits between the core and the board SRAM/SDRAM-facing pins.

Parameters:
WAIT_CYCLES, 2, extra wait states per 16-bit memory access; each access holds strobes for WAIT_CYCLES+1 cycles (legal range 0..15)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset
cpu_addr  in  16  request address (data word address, or instruction word address)
cpu_wdata  in  16  write data
cpu_read  in  1  read request level, held by core until ready
cpu_write  in  1  write request level, held by core until ready
cpu_instr  in  1  request targets instruction space
cpu_read_done  in  1  core has consumed read data
cpu_rdata  out  16  read data (low half for instruction fetches)
cpu_idata  out  32  assembled instruction word
cpu_busy  out  1  access in progress
cpu_ready  out  1  access complete / data valid
mem_addr  out  17  {space bit, word address}; space 1 = instruction
mem_half  out  1  instruction half select (0 = bits 15:0, 1 = bits 31:16)
mem_wdata  out  16  write data to memory
mem_rdata  in  16  memory read data, valid on last strobe cycle
mem_we  out  1  write strobe
mem_oe  out  1  read strobe

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0; state IDLE; wait counter 0.
  - mem_we and mem_oe drop without waiting for clk.
  - An access in flight is abandoned; no ready is produced after release.
- All outputs are registered.
- States:
  - IDLE, RD_LO, RD_HI, WR, HOLD, WDONE.
  - Wait counter counts 0..WAIT_CYCLES in RD_LO, RD_HI and WR, reloads to 0 on each state entry.
- IDLE:
  - busy=0, ready=0; requests sampled each cycle.
  - cpu_write=1: latch addr/wdata/instr; go WR.
  - Else cpu_read=1: latch addr/instr; go RD_LO.
  - Both high: write wins; read stays pending and is taken after WDONE.
- WR:
  - busy=1, mem_we=1, mem_addr={instr,addr}, mem_half=0, mem_wdata=latched data.
  - When the counter reaches WAIT_CYCLES, go WDONE.
- WDONE:
  - busy=0, ready=1 for exactly one cycle, then IDLE.
- RD_LO:
  - busy=1, mem_oe=1, mem_half=0.
  - On the last count, capture mem_rdata into cpu_rdata and cpu_idata[15:0].
  - Go RD_HI if instr, else HOLD.
- RD_HI:
  - busy=1, mem_oe=1, mem_half=1.
  - On the last count, capture mem_rdata into cpu_idata[31:16]; go HOLD.
- HOLD:
  - busy=0, ready=1; cpu_rdata and cpu_idata stable.
  - Stay until cpu_read_done=1, then IDLE with ready=0.
  - cpu_read/cpu_write are ignored while in HOLD.
- Latency, request sampled at edge 0:
  - Data read: strobe cycles 1..WAIT_CYCLES+1; ready from cycle WAIT_CYCLES+2.
  - Instruction read: ready from cycle 2*WAIT_CYCLES+3.
  - Write: ready pulse at cycle WAIT_CYCLES+2.
- Outside strobe states: mem_addr, mem_half and mem_wdata hold their last values; strobes are 0.
- Requests arriving while busy are not queued beyond the level the core holds.
- A new access may begin the cycle after returning to IDLE; no back-to-back bypass.

Optional Feature:
MEM_BRIDGE_IBUF_EN
- Defined: adds a one-entry instruction buffer holding {valid, addr, 32-bit word}, loaded on completion of each RD_HI.
- An instruction read in IDLE whose addr matches a valid entry goes directly to HOLD with the buffered word; no mem_oe; ready at cycle 1.
- Any write, whatever the space, clears valid. Reset clears valid.
- Undefined: no buffer; every fetch goes to memory.

Test Plan:
- WAIT_CYCLES=2, data read 0x1234, mem_rdata=0xBEEF -> mem_oe cycles 1-3, mem_addr=0x01234; ready from cycle 4; cpu_rdata=0xBEEF held until read_done; ready=0 the cycle after.
- Write 0x0042 <- 0xA5A5 -> mem_we cycles 1-3, mem_addr=0x00042, mem_wdata=0xA5A5, busy cycles 1-3, ready single pulse at cycle 4.
- Instruction fetch 0x0010; halves 0x1111 then 0x2222 -> mem_addr=0x10010 on both, mem_half 0 then 1; cpu_idata=0x22221111; ready at cycle 7.
- cpu_read and cpu_write both high in IDLE -> write completes (WDONE), then read begins from IDLE; exactly one ready per access.
- rst low at cycle 2 of a read -> mem_oe, busy and ready go 0 asynchronously; no ready after release while requests are low.
- With MEM_BRIDGE_IBUF_EN, fetch 0x0010 twice -> second fetch gives ready at cycle 1 with no mem_oe; after any write, the third fetch of 0x0010 accesses memory again.
